demux8_buf: RTL and testbench

- Eight-way registered demultiplexer: the write-side counterpart of the processor's 8:1 select mux.
- Steers one WIDTH-bit source word, chosen by a 3-bit select, into one of eight single-entry holding registers.
- Each holding register has its own valid/ready handshake toward a downstream consumer.
- Used in the datapath to fan results or memory-mapped writes out to eight sinks, with back-pressure per sink.

---
 rtl/demux8_buf.sv | 121 ++++++++++++
 tb/tb_demux8_buf.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/demux8_buf.sv
// demux8_buf: eight-way registered demultiplexer with per-channel valid/ready.
// A source word (In) is steered by Sel into one of eight single-entry holding
// registers. Each register drains independently toward its own consumer.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   In, Sel, In_Valid    source word, destination channel, source valid
//   In_Ready             combinational: channel Sel can take a word this cycle
//   Out0..Out7           holding register contents
//   Out_Valid[7:0]       per-channel "holds an unconsumed word"
//   Out_Ready[7:0]       per-channel consumer take strobe
//   Occupancy[3:0]       registered count of valid channels (0..8)

// One holding register: EMPTY <-> FULL element with a write strobe.
module demux8_buf_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,     // accept into this channel this cycle
  input  logic [WIDTH-1:0] data_i,
  input  logic             rdy_i,    // consumer takes the word this cycle
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o,
  output logic             vld_d_o   // next-state valid, for the occupancy count
);
  logic [WIDTH-1:0] data_q;
  logic             vld_q, vld_d;

  // A write keeps/sets valid even when the old word is consumed in the same
  // cycle; a consume without write empties the slot. Ready while empty is
  // harmless since it only clears an already-clear bit.
  always_comb begin
    vld_d = wr_i | (vld_q & ~rdy_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (wr_i) data_q <= data_i;
      vld_q <= vld_d;
    end
  end

  assign data_o  = data_q;
  assign vld_o   = vld_q;
  assign vld_d_o = vld_d;
endmodule

module demux8_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In,
  input  logic [2:0]       Sel,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out0,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic [WIDTH-1:0] Out4,
  output logic [WIDTH-1:0] Out5,
  output logic [WIDTH-1:0] Out6,
  output logic [WIDTH-1:0] Out7,
  output logic [7:0]       Out_Valid,
  input  logic [7:0]       Out_Ready,
  output logic [3:0]       Occupancy
);
  localparam int NUM_CH = 8;

  logic [NUM_CH-1:0][WIDTH-1:0] data;
  logic [NUM_CH-1:0]            vld, vld_d, wr;
  logic                         acc;
  logic [3:0]                   occ_q, occ_d;

  // Only channel Sel is looked at: a stalled word blocks the source even if
  // other channels are empty (no head-of-line bypass).
  assign In_Ready = ~vld[Sel] | Out_Ready[Sel];
  assign acc      = In_Valid & In_Ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = acc & (Sel == 3'(g));
    demux8_buf_chan #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .wr_i   (wr[g]),
      .data_i (In),
      .rdy_i  (Out_Ready[g]),
      .data_o (data[g]),
      .vld_o  (vld[g]),
      .vld_d_o(vld_d[g])
    );
  end

  // Occupancy is the popcount of next-state valid so it lands on the same
  // edge as Out_Valid.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < NUM_CH; i++) occ_d = occ_d + 4'(vld_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign Out0      = data[0];
  assign Out1      = data[1];
  assign Out2      = data[2];
  assign Out3      = data[3];
  assign Out4      = data[4];
  assign Out5      = data[5];
  assign Out6      = data[6];
  assign Out7      = data[7];
  assign Out_Valid = vld;
  assign Occupancy = occ_q;
endmodule

// File: tb/tb_demux8_buf.sv
// Bench for demux8_buf: directed stimulus, a behavioural channel model checked
// on every falling edge, plus literal expectations for the listed scenarios.
module tb_demux8_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_w = '0;
  logic [2:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [3:0]  occupancy;
  logic [31:0] outs [8];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: per-channel word and valid flag.
  logic [31:0] m_data [8];
  bit          m_vld  [8];
  int          m_occ;

  always #5 clk = ~clk;

  demux8_buf #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .In(in_w), .Sel(sel), .In_Valid(in_valid),
    .In_Ready(in_ready),
    .Out0(o0), .Out1(o1), .Out2(o2), .Out3(o3),
    .Out4(o4), .Out5(o5), .Out6(o6), .Out7(o7),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Occupancy(occupancy)
  );

  assign outs[0] = o0; assign outs[1] = o1; assign outs[2] = o2; assign outs[3] = o3;
  assign outs[4] = o4; assign outs[5] = o5; assign outs[6] = o6; assign outs[7] = o7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a full slot with its consumer ready empties; an accepted word
  // fills slot Sel. Accept is allowed when slot Sel is empty or draining.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_data[i] = '0; m_vld[i] = 0; end
      m_occ = 0;
    end else begin
      bit take;
      take = in_valid && (!m_vld[sel] || out_ready[sel]);
      for (int i = 0; i < 8; i++) if (m_vld[i] && out_ready[i]) m_vld[i] = 0;
      if (take) begin m_vld[sel] = 1; m_data[sel] = in_w; end
      m_occ = 0;
      for (int i = 0; i < 8; i++) m_occ += int'(m_vld[i]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] mv;
      for (int i = 0; i < 8; i++) begin
        mv[i] = m_vld[i];
        chk($sformatf("model Out%0d", i), outs[i], m_data[i]);
      end
      chk("model Out_Valid", 32'(out_valid), 32'(mv));
      chk("model Occupancy", 32'(occupancy), 32'(m_occ));
      chk("model In_Ready", 32'(in_ready), 32'(!mv[sel] || out_ready[sel]));
    end
  end

  // Apply inputs, then advance one rising edge and settle.
  task automatic cyc(input bit v, input logic [2:0] s, input logic [31:0] d, input logic [7:0] r);
    in_valid = v; sel = s; in_w = d; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1; cyc(0, 0, 0, 0); rst = 0;
  endtask

  initial begin
    rst = 1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 0;
    chk_en = 1;
    chk("reset Out_Valid", 32'(out_valid), 32'h00);
    chk("reset Occupancy", 32'(occupancy), 32'd0);
    chk("reset Out3", o3, 32'h0);

    // 1: single write into channel 3
    cyc(1, 3, 32'hDEADBEEF, 8'h00); idle();
    chk("t1 Out3", o3, 32'hDEADBEEF);
    chk("t1 Out_Valid", 32'(out_valid), 32'h08);
    chk("t1 Occupancy", 32'(occupancy), 32'd1);
    chk("t1 Out0", o0, 32'h0);
    chk("t1 Out7", o7, 32'h0);

    // 2: fill all, then a write to full channel 5 stalls
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 3'(i), 32'(i + 1), 8'h00);
    idle();
    chk("t2 Out_Valid", 32'(out_valid), 32'hFF);
    chk("t2 Occupancy", 32'(occupancy), 32'd8);
    in_valid = 1; sel = 5; in_w = 32'h99; #1;
    chk("t2 In_Ready", 32'(in_ready), 32'd0);
    cyc(1, 5, 32'h99, 8'h00); idle();
    chk("t2 Out5", o5, 32'd6);
    chk("t2 Occupancy hold", 32'(occupancy), 32'd8);

    // 3: accept and consume on the same channel
    do_reset();
    cyc(1, 2, 32'h11, 8'h00); idle();
    in_valid = 1; sel = 2; in_w = 32'h22; out_ready = 8'h04; #1;
    chk("t3 In_Ready", 32'(in_ready), 32'd1);
    cyc(1, 2, 32'h22, 8'h04); idle();
    chk("t3 Out2", o2, 32'h22);
    chk("t3 Out_Valid", 32'(out_valid), 32'h04);
    chk("t3 Occupancy", 32'(occupancy), 32'd1);

    // 4: accept on 4 while consuming 1, channel 6 untouched
    do_reset();
    cyc(1, 1, 32'hA1, 8'h00);
    cyc(1, 6, 32'hA6, 8'h00);
    cyc(1, 4, 32'h55, 8'h02); idle();
    chk("t4 Out_Valid", 32'(out_valid), 32'h50);
    chk("t4 Occupancy", 32'(occupancy), 32'd2);
    chk("t4 Out1 retained", o1, 32'hA1);
    chk("t4 Out4", o4, 32'h55);

    // 5: stall on full channel 0, then retarget to empty channel 7
    do_reset();
    cyc(1, 0, 32'hC0, 8'h00);
    in_valid = 1; sel = 0; in_w = 32'h77; #1;
    chk("t5 stall In_Ready", 32'(in_ready), 32'd0);
    cyc(1, 0, 32'h77, 8'h00);
    chk("t5 stall Out0", o0, 32'hC0);
    sel = 7; #1;
    chk("t5 retarget In_Ready", 32'(in_ready), 32'd1);
    cyc(1, 7, 32'h77, 8'h00); idle();
    chk("t5 Out7", o7, 32'h77);
    chk("t5 Out_Valid", 32'(out_valid), 32'h81);

    // 6: reset wins over a pending accept
    do_reset();
    cyc(1, 0, 32'hF0, 8'h00);
    cyc(1, 2, 32'hF2, 8'h00);
    cyc(1, 5, 32'hF5, 8'h00);
    cyc(1, 7, 32'hF7, 8'h00); idle();
    chk("t6 pre Out_Valid", 32'(out_valid), 32'hA5);
    rst = 1;
    cyc(1, 1, 32'hBAD, 8'h00);
    rst = 0; idle();
    chk("t6 Out_Valid", 32'(out_valid), 32'h00);
    chk("t6 Occupancy", 32'(occupancy), 32'd0);
    chk("t6 Out1", o1, 32'h0);
    chk("t6 Out7", o7, 32'h0);

    // drain mix: consume some after refill, model tracks the rest
    cyc(1, 3, 32'h33, 8'h00);
    cyc(1, 4, 32'h44, 8'h08);
    cyc(0, 0, 32'h0,  8'hFF);
    idle(); cyc(0, 0, 0, 0);
    chk("drain Occupancy", 32'(occupancy), 32'd0);
    chk("drain Out4 held", o4, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
